// File: rtl/note_player_pkg.sv
// Shared widths, state encoding and pitch table for the note player.
// Half-periods are in clock cycles for the middle octave.
package note_player_pkg;

  localparam int OCTAVE_BITS    = 2;
  localparam int NOTE_BITS      = 3;
  localparam int LENGTH_BITS    = 5;
  localparam int FULL_NOTE_BITS = 8;
  localparam int HP_BITS        = 19;
  localparam int TICK_CNT_BITS  = 12;

  typedef logic [0:6][HP_BITS-1:0] hp_table_t;

  // C, D, E, F, G, A, B at 100 MHz
  localparam hp_table_t MID_HP_100M = '{
    19'd191110, 19'd170265, 19'd151686,
    19'd143172, 19'd127551, 19'd113636,
    19'd101239
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic hp_table_t scale_table(
    input hp_table_t t,
    input longint    clk_hz
  );
    hp_table_t r;
    longint    v;
    for (int i = 0; i < 7; i++) begin
      v    = (longint'(t[i]) * clk_hz) / 64'd100_000_000;
      r[i] = HP_BITS'(v);
    end
    return r;
  endfunction

  function automatic logic [HP_BITS-1:0] octave_hp(
    input logic [HP_BITS-1:0]     base,
    input logic [OCTAVE_BITS-1:0] oct
  );
    logic [HP_BITS-1:0] r;
    unique case (1'b1)
      oct == 2'd0: r = base << 1;
      oct == 2'd1: r = base;
      default:     r = base >> 1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/note_player_tone_divider.sv
// Square-wave generator: toggles each time the counter hits half_period-1.
// restart holds the phase at zero with the output low.
module tone_divider
  import note_player_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [HP_BITS-1:0] half_period,
  input  logic               mute,
  output logic               wave
);

  logic [HP_BITS-1:0] r_cnt;
  logic               r_wave;
  logic [HP_BITS:0]   w_cnt_p1;
  logic               w_hit;

  assign w_cnt_p1 = {1'b0, r_cnt} + {{HP_BITS{1'b0}}, 1'b1};
  // widened compare so a zero half-period toggles every cycle
  assign w_hit    = w_cnt_p1 >= {1'b0, half_period};

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (w_hit) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= w_cnt_p1[HP_BITS-1:0];
    end
  end

  assign wave = r_wave & ~mute;

endmodule

// File: rtl/note_player.sv
// Plays one latched note for length*full_note ticks, then pulses over.
// Owns the FSM and duration counters; pitch comes from tone_divider.
module note_player
  import note_player_pkg::*;
#(
  parameter int        CLK_HZ      = 100_000_000,
  parameter int        TICK_CYCLES = 62_500,
  parameter int        GAP_TICKS   = 16,
  parameter hp_table_t HP_TABLE    =
    scale_table(MID_HP_100M, longint'(CLK_HZ))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [OCTAVE_BITS-1:0]    octave,
  input  logic [NOTE_BITS-1:0]      note,
  input  logic [LENGTH_BITS-1:0]    length,
  input  logic [FULL_NOTE_BITS-1:0] full_note,
  output logic                      buzzer,
  output logic                      over,
  output logic                      busy
);

  localparam int TICK_W =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_CNT_BITS-1:0] GAP_T =
    TICK_CNT_BITS'(GAP_TICKS);

  state_t r_state;
  state_t w_next;
  logic   r_over;
  logic   r_busy;

  logic [OCTAVE_BITS-1:0]    r_oct;
  logic [NOTE_BITS-1:0]      r_note;
  logic [LENGTH_BITS-1:0]    r_len;
  logic [FULL_NOTE_BITS-1:0] r_fn;

  logic [TICK_W-1:0]         r_tick;
  logic [FULL_NOTE_BITS-1:0] r_sub;
  logic [LENGTH_BITS-1:0]    r_six;
  logic [TICK_CNT_BITS-1:0]  r_etick;

  logic                      w_tick_wrap;
  logic                      w_six_wrap;
  logic                      w_end;
  logic [TICK_CNT_BITS-1:0]  w_total;
  logic                      w_gap;
  logic                      w_mute;
  logic                      w_restart;
  logic [HP_BITS-1:0]        w_base;
  logic [HP_BITS-1:0]        w_hp;
  logic                      w_wave;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_six_wrap  = w_tick_wrap &&
    (r_sub == r_fn - FULL_NOTE_BITS'(1));
  assign w_end       = w_six_wrap &&
    (r_six == r_len - LENGTH_BITS'(1));

  assign w_total = TICK_CNT_BITS'(r_len) *
                   TICK_CNT_BITS'(r_fn);
  assign w_gap   = (w_total > GAP_T) &&
                   (r_etick >= w_total - GAP_T);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_LOAD;
      S_LOAD: w_next = (length == '0) ? S_DONE : S_PLAY;
      S_PLAY: if (w_end) w_next = S_DONE;
      S_DONE: w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
    if (!en) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_over  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_over  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oct  <= '0;
      r_note <= '0;
      r_len  <= '0;
      r_fn   <= '0;
    end else if (r_state == S_LOAD) begin
      r_oct  <= octave;
      r_note <= note;
      r_len  <= length;
      r_fn   <= (full_note == '0) ?
                FULL_NOTE_BITS'(1) : full_note;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_PLAY) begin
      r_tick  <= '0;
      r_sub   <= '0;
      r_six   <= '0;
      r_etick <= '0;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
      if (w_tick_wrap)
        r_etick <= r_etick + TICK_CNT_BITS'(1);
      if (w_six_wrap) begin
        r_sub <= '0;
        r_six <= r_six + LENGTH_BITS'(1);
      end else if (w_tick_wrap) begin
        r_sub <= r_sub + FULL_NOTE_BITS'(1);
      end
    end
  end

  always_comb begin
    w_base = '0;
    for (int i = 0; i < 7; i++)
      if (r_note == NOTE_BITS'(i + 1))
        w_base = HP_TABLE[i];
  end

  assign w_hp      = octave_hp(w_base, r_oct);
  assign w_restart = (r_state != S_PLAY);
  assign w_mute    = w_restart || (r_note == '0) || w_gap;

  tone_divider u_tone (
    .clk         (clk),
    .rst         (rst),
    .restart     (w_restart),
    .half_period (w_hp),
    .mute        (w_mute),
    .wave        (w_wave)
  );

  assign buzzer = w_wave;
  assign over   = r_over;
  assign busy   = r_busy;

endmodule

// File: tb/tb_note_player.sv
// Directed stimulus with a note-completion scoreboard for note_player.
// Monitor measures each note's over cycle, tone period and gap on over.
module tb_note_player;
  import note_player_pkg::*;

  localparam int TC  = 4;
  localparam int GAP = 2;
  localparam hp_table_t TB_HP = '{
    19'd3, 19'd4, 19'd6, 19'd7,
    19'd8, 19'd5, 19'd9
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] octave;
  logic [2:0] note;
  logic [4:0] length;
  logic [7:0] full_note;
  logic       buzzer;
  logic       over;
  logic       busy;

  note_player #(
    .CLK_HZ      (100_000_000),
    .TICK_CYCLES (TC),
    .GAP_TICKS   (GAP),
    .HP_TABLE    (TB_HP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .octave    (octave),
    .note      (note),
    .length    (length),
    .full_note (full_note),
    .buzzer    (buzzer),
    .over      (over),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ocyc;
    int hi;
    int per;
    int quiet;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor
  int   m_hi = 0;
  int   m_r1 = -1;
  int   m_r2 = -1;
  int   m_last = -1;
  logic m_prev = 1'b0;
  int   idle_bz = 0;
  int   m_per;

  always @(negedge clk) begin
    if (!busy) begin
      if (buzzer) idle_bz++;
      m_hi = 0; m_r1 = -1; m_r2 = -1;
      m_last = -1; m_prev = 1'b0;
    end else if (over) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_over at cycle %0d", cyc);
      end else begin
        m_e   = sb.pop_front();
        m_per = (m_r2 >= 0) ? (m_r2 - m_r1) : 0;
        chk("over_cycle", cyc, m_e.ocyc);
        chk("buzzer_high_cycles", m_hi, m_e.hi);
        chk("buzzer_period", m_per, m_e.per);
        if (m_e.quiet >= 0)
          chk("gap_quiet", cyc - m_last, m_e.quiet);
      end
      m_hi = 0; m_r1 = -1; m_r2 = -1;
      m_last = -1; m_prev = 1'b0;
    end else begin
      if (buzzer) begin
        m_hi++;
        m_last = cyc;
        if (!m_prev) begin
          if (m_r1 < 0) m_r1 = cyc;
          else if (m_r2 < 0) m_r2 = cyc;
        end
      end
      m_prev = buzzer;
    end
  end

  // Stimulus helpers
  task automatic start(input logic [1:0] o, input logic [2:0] n,
                       input logic [4:0] l, input logic [7:0] f,
                       output int c0);
    octave = o; note = n; length = l; full_note = f;
    en = 1'b1;
    c0 = cyc;
  endtask

  task automatic push(input int c0, input int d, input int hi,
                      input int per, input int quiet);
    exp_t e;
    e.ocyc = c0 + 2 + d;
    e.hi = hi;
    e.per = per;
    e.quiet = quiet;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d notes pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [2:0] n,
                     input logic [4:0] l, input logic [7:0] f,
                     input int d, input int hi, input int per,
                     input int quiet);
    int c0;
    @(negedge clk);
    start(o, n, l, f, c0);
    push(c0, d, hi, per, quiet);
    wait_empty(200);
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    rst = 1'b1; en = 1'b0;
    octave = '0; note = '0; length = '0; full_note = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_over", int'(over), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // back-to-back: A middle, then A high latched in LOAD
    @(negedge clk);
    start(2'd1, 3'd6, 5'd3, 8'd2, c0);
    push(c0, 24, 6, 10, 9);
    push(c0 + 26, 24, 8, 4, 9);
    @(negedge clk);
    chk("busy_cycle1", int'(busy), 1);
    repeat (26) @(negedge clk);
    octave = 2'd2;
    wait_empty(200);
    en = 1'b0;
    repeat (2) @(negedge clk);

    run(2'd0, 3'd6, 5'd8, 8'd2, 64, 26, 20, 9);
    run(2'd3, 3'd6, 5'd3, 8'd2, 24, 8, 4, 9);
    run(2'd1, 3'd0, 5'd2, 8'd2, 16, 0, 0, -1);
    run(2'd1, 3'd6, 5'd2, 8'd2, 16, 3, 0, 9);
    run(2'd1, 3'd6, 5'd0, 8'd2, 0, 0, 0, -1);
    run(2'd1, 3'd6, 5'd1, 8'd0, 4, 0, 0, -1);
    run(2'd1, 3'd6, 5'd1, 8'd2, 8, 3, 0, 1);

    // abort by en low at PLAY cycle 10
    @(negedge clk);
    start(2'd1, 3'd6, 5'd3, 8'd2, c0);
    repeat (12) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_buzzer", int'(buzzer), 0);
    chk("abort_over", int'(over), 0);
    repeat (40) @(negedge clk);

    // reset mid-note with en held high
    @(negedge clk);
    start(2'd1, 3'd6, 5'd3, 8'd2, c0);
    repeat (9) @(negedge clk);
    chk("pre_rst_buzzer", int'(buzzer), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_buzzer", int'(buzzer), 0);
    chk("midrst_over", int'(over), 0);
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    push(r, 24, 6, 10, 9);
    chk("post_rst_idle", int'(busy), 0);
    @(negedge clk);
    chk("post_rst_load", int'(busy), 1);
    wait_empty(200);
    en = 1'b0;
    repeat (4) @(negedge clk);

    chk("idle_buzzer_silent", idle_bz, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
